// File: rtl/fetch_controller.sv
// Instruction fetch front end: 2-entry {pc,instr} buffer, 2 cycles issue-to-valid, 1 word/cycle, stalls issue on out_ready=0.
// Optional transfer counter port fetch_count is built when FETCH_COUNT_EN is defined.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_sel,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  logic [31:0] r_pc_f;
  logic        r_inf_vld;
  logic [31:0] r_inf_pc;
  logic [31:0] r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic [31:0] w_target;
  logic        w_xfer;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_occ;
  logic        w_unused_lsb;

  assign w_target     = {redirect_pc[31:2], 2'b00};
  assign w_unused_lsb = ^redirect_pc[1:0];
  assign imem_sel     = redirect ? w_target : r_pc_f;

  assign out_valid = (r_count != 2'd0);
  assign out_pc    = r_fifo_pc[r_rd_ptr];
  assign out_instr = r_fifo_instr[r_rd_ptr];
  assign w_xfer    = out_valid && out_ready;

  // Buffered words plus the one in flight must fit in the buffer after this cycle's pop.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inf_vld} - {2'b00, w_xfer};
  assign w_issue = redirect || (w_occ < 3'd2);
  assign w_push  = r_inf_vld && !redirect;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc_f    <= RESET_PC;
      r_inf_vld <= 1'b0;
      r_inf_pc  <= RESET_PC;
    end else if (w_issue) begin
      r_inf_vld <= 1'b1;
      r_inf_pc  <= imem_sel;
      r_pc_f    <= imem_sel + 32'd4;
    end else begin
      r_inf_vld <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || redirect) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_xfer) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_xfer};
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_inf_pc;
      r_fifo_instr[r_wr_ptr] <= imem_data;
    end
  end

`ifdef FETCH_COUNT_EN
  // A head transfer in a redirect cycle still counts.
  always_ff @(posedge clock) begin
    if (reset)       fetch_count <= 32'd0;
    else if (w_xfer) fetch_count <= fetch_count + 32'd1;
  end
`else
  // No transfer counter in this build.
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, reset corner sequence, then randomized run against a program-order model.
module tb_fetch_controller;
  localparam logic [31:0] RST = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_sel;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_cnt = 32'd0;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] sel;
  } vec_t;
  vec_t tbl [22];

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + {a[15:0], a[31:16]};
  endfunction

  // Instruction memory: samples the address on posedge, data valid the following cycle.
  always @(posedge clock) imem_data <= mem_word(imem_sel);

  fetch_controller #(.RESET_PC(RST)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_sel    (imem_sel),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
`ifdef FETCH_COUNT_EN
    chk(name, fetch_count, model_cnt);
`else
    if (name.len() == 0) $display("empty counter check name");
`endif
  endtask

  task automatic drive(input logic rst, input logic rd, input logic [31:0] rpc, input logic rdy);
    @(negedge clock);
    reset       = rst;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
  endtask

  task automatic set_row(input int i, input logic rd, input logic [31:0] rpc, input logic rdy,
                         input logic vld, input logic [31:0] pc, input logic [31:0] sel);
    tbl[i].rd  = rd;
    tbl[i].rpc = rpc;
    tbl[i].rdy = rdy;
    tbl[i].vld = vld;
    tbl[i].pc  = pc;
    tbl[i].sel = sel;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] rpc;
    logic        rd;
    logic        rdy;
    int          since;

    // Cycle-by-cycle from reset release: fill, 5-cycle stall, redirect to 0xE, redirect to wrap region.
    set_row(0,  1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          RST);
    set_row(1,  1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          RST + 32'd4);
    set_row(2,  1'b0, 32'h0,          1'b0, 1'b1, RST,            RST + 32'd8);
    for (int i = 3; i <= 6; i++)
      set_row(i, 1'b0, 32'h0,         1'b0, 1'b1, RST,            RST + 32'd8);
    set_row(7,  1'b0, 32'h0,          1'b1, 1'b1, RST,            RST + 32'd8);
    set_row(8,  1'b0, 32'h0,          1'b1, 1'b1, RST + 32'd4,    RST + 32'd12);
    set_row(9,  1'b0, 32'h0,          1'b1, 1'b1, RST + 32'd8,    RST + 32'd16);
    set_row(10, 1'b1, 32'h0000_000E,  1'b1, 1'b1, RST + 32'd12,   32'h0000_000C);
    set_row(11, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          32'h0000_0010);
    set_row(12, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_000C,  32'h0000_0014);
    set_row(13, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0010,  32'h0000_0018);
    set_row(14, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0014,  32'h0000_001C);
    set_row(15, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0018,  32'h0000_0020);
    set_row(16, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_001C,  32'h0000_0024);
    set_row(17, 1'b1, 32'hFFFF_FFF8,  1'b1, 1'b1, 32'h0000_0020,  32'hFFFF_FFF8);
    set_row(18, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          32'hFFFF_FFFC);
    set_row(19, 1'b0, 32'h0,          1'b1, 1'b1, 32'hFFFF_FFF8,  32'h0000_0000);
    set_row(20, 1'b0, 32'h0,          1'b1, 1'b1, 32'hFFFF_FFFC,  32'h0000_0004);
    set_row(21, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0000_0000,  32'h0000_0008);

    // Reset overrides a concurrent redirect and handshake.
    drive(1'b1, 1'b1, 32'h40, 1'b1);
    drive(1'b1, 1'b1, 32'h40, 1'b1);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    model_cnt = 32'd0;

    for (int i = 0; i < 22; i++) begin
      drive(1'b0, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].vld});
      chk($sformatf("vec%0d_sel", i), imem_sel, tbl[i].sel);
      if (tbl[i].vld) begin
        chk($sformatf("vec%0d_pc", i), out_pc, tbl[i].pc);
        chk($sformatf("vec%0d_instr", i), out_instr, mem_word(tbl[i].pc));
      end
      chk_cnt($sformatf("vec%0d_count", i));
      if (tbl[i].vld && tbl[i].rdy) model_cnt = model_cnt + 32'd1;
    end

    // Reset while a word is in flight, with redirect asserted: stale data must be dropped.
    drive(1'b1, 1'b1, 32'h40, 1'b0);
    model_cnt = 32'd0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_sel", imem_sel, RST);
    chk_cnt("rst2_count");
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst2_valid_c1", {31'd0, out_valid}, 32'd0);
    chk("rst2_sel_c1", imem_sel, RST + 32'd4);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst2_valid_c2", {31'd0, out_valid}, 32'd1);
    chk("rst2_pc", out_pc, RST);
    chk("rst2_instr", out_instr, mem_word(RST));
    model_cnt = model_cnt + 32'd1;

    // Random run: every delivered word must be next in program order from the last flush point.
    exp_pc = RST + 32'd4;
    since  = 4;
    for (int n = 0; n < 3000; n++) begin
      rd  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rdy = ($urandom_range(0, 9) < 7);
      drive(1'b0, rd, rpc, rdy);
      if (rd) chk("rand_sel", imem_sel, rpc & 32'hFFFF_FFFC);
      if (since == 1)      chk("rand_flushed", {31'd0, out_valid}, 32'd0);
      else if (since >= 2) chk("rand_live", {31'd0, out_valid}, 32'd1);
      if (out_valid) begin
        chk("rand_pc", out_pc, exp_pc);
        chk("rand_instr", out_instr, mem_word(exp_pc));
      end
      chk_cnt("rand_count");
      if (out_valid && rdy) begin
        exp_pc    = exp_pc + 32'd4;
        model_cnt = model_cnt + 32'd1;
      end
      if (rd) begin
        exp_pc = rpc & 32'hFFFF_FFFC;
        since  = 1;
      end else begin
        since++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
